// File: rtl/volume_ctrl_pkg.sv
// Shared types and constants for the volume level sequencer.
//   level_t      : 2-bit volume level (0 = off, 3 = full)
//   vseq_state_t : sequencer FSM state {IDLE, RAMP}
//   step_toward  : one-step move of a level toward a goal
package volume_ctrl_pkg;

  typedef logic [1:0] level_t;

  localparam level_t LEVEL_OFF  = 2'b00;
  localparam level_t LEVEL_FULL = 2'b11;

  typedef enum logic {IDLE, RAMP} vseq_state_t;

  // Only called when cur != goal, so the result never wraps.
  function automatic level_t step_toward(input level_t cur, input level_t goal);
    if (goal > cur) begin
      return level_t'(cur + 2'd1);
    end
    return level_t'(cur - 2'd1);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Loadable down-counter advanced by sample_tick; flags when the count is zero.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   load, load_value  : load the counter (priority below clear)
//   clear             : force the counter to zero
//   tick              : decrement strobe; the counter holds at zero
//   cnt, zero         : current count and (cnt == 0)
module tick_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/volume_level_sequencer.sv
// Volume level sequencer: keeps a user target level (plus optional mute) and
// walks the applied level toward it one step per RAMP_TICKS sample ticks.
// Optional feature: define VOLUME_MUTE_EN to enable the mute register; when
// undefined mute_toggle is ignored and muted is tied low.
// Ports:
//   clock, reset               : clock and synchronous active-high reset
//   vol_up, vol_down           : single-cycle key pulses adjusting target
//   mute_toggle                : single-cycle pulse toggling mute
//   sample_tick                : one-cycle strobe per audio sample
//   level                      : applied level to the volume datapath
//   target                     : user-selected level (held through mute)
//   muted                      : mute state
//   ramping                    : high while level differs from goal
module volume_level_sequencer
  import volume_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_TICKS = 480,
  parameter logic [1:0]  INIT_LEVEL = 2'b11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vol_up,
  input  logic       vol_down,
  input  logic       mute_toggle,
  input  logic       sample_tick,
  output logic [1:0] level,
  output logic [1:0] target,
  output logic       muted,
  output logic       ramping
);

  localparam logic [15:0] Reload = 16'(RAMP_TICKS - 1);

  level_t      target_q, target_d;
  level_t      level_q, level_d;
  level_t      goal;
  vseq_state_t state_q, state_d;
  logic        ramping_q;
  logic        muted_s;
  logic        cnt_load, cnt_clear, cnt_zero, step;
  logic [15:0] cnt;

  // Target register: saturating, conflicting keys cancel.
  always_comb begin
    target_d = target_q;
    if (vol_up && !vol_down && (target_q != LEVEL_FULL)) begin
      target_d = level_t'(target_q + 2'd1);
    end else if (vol_down && !vol_up && (target_q != LEVEL_OFF)) begin
      target_d = level_t'(target_q - 2'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      target_q <= INIT_LEVEL;
    end else begin
      target_q <= target_d;
    end
  end

`ifdef VOLUME_MUTE_EN
  logic muted_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      muted_q <= 1'b0;
    end else if (mute_toggle) begin
      muted_q <= ~muted_q;
    end
  end

  assign muted_s = muted_q;
`else
  logic unused_mute_toggle;
  assign unused_mute_toggle = mute_toggle;
  assign muted_s            = 1'b0;
`endif

  // Uses the registered target/mute, so a same-cycle key pulse does not
  // affect a step taken in that cycle.
  assign goal = muted_s ? LEVEL_OFF : target_q;

  tick_divider #(
    .WIDTH(16)
  ) u_div (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .clear      (cnt_clear),
    .load_value (Reload),
    .tick       (sample_tick),
    .cnt        (cnt),
    .zero       (cnt_zero)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and counter control.
  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (goal != level_q) begin
          state_d  = RAMP;
          cnt_load = 1'b1;
        end
      end
      RAMP: begin
        if (goal == level_q) begin
          // Goal moved back onto the current level.
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end else if (sample_tick && cnt_zero) begin
          step = 1'b1;
          if (step_toward(level_q, goal) == goal) begin
            state_d = IDLE;
          end else begin
            cnt_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: level step.
  always_comb begin
    level_d = level_q;
    if (step) begin
      level_d = step_toward(level_q, goal);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q   <= INIT_LEVEL;
      ramping_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      ramping_q <= (state_d == RAMP);
    end
  end

  assign level   = level_q;
  assign target  = target_q;
  assign muted   = muted_s;
  assign ramping = ramping_q;

endmodule

// File: tb/tb_volume_level_sequencer.sv
// Self-checking bench for volume_level_sequencer (RAMP_TICKS = 4).
module tb_volume_level_sequencer;

  localparam int RT = 4;

  logic       clock = 1'b0;
  logic       reset, vol_up, vol_down, mute_toggle, sample_tick;
  logic [1:0] level, target;
  logic       muted, ramping;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_target, m_level, m_ticks;
  bit m_muted, m_ramp;

  always #5 clock = ~clock;

  volume_level_sequencer #(
    .RAMP_TICKS (RT),
    .INIT_LEVEL (2'b11)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vol_up      (vol_up),
    .vol_down    (vol_down),
    .mute_toggle (mute_toggle),
    .sample_tick (sample_tick),
    .level       (level),
    .target      (target),
    .muted       (muted),
    .ramping     (ramping)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: counts ticks seen while ramping, steps on the RT-th.
  task automatic model_step();
    int goal;
    if (reset) begin
      m_target = 3; m_level = 3; m_muted = 0; m_ramp = 0; m_ticks = 0;
      return;
    end
    goal = m_muted ? 0 : m_target;
    if (!m_ramp) begin
      if (goal != m_level) begin
        m_ramp  = 1;
        m_ticks = 0;
      end
    end else if (goal == m_level) begin
      m_ramp = 0;
    end else if (sample_tick) begin
      m_ticks++;
      if (m_ticks == RT) begin
        m_ticks = 0;
        m_level = (goal > m_level) ? m_level + 1 : m_level - 1;
        if (m_level == goal) m_ramp = 0;
      end
    end
    if (vol_up && !vol_down && m_target < 3) m_target++;
    else if (vol_down && !vol_up && m_target > 0) m_target--;
`ifdef VOLUME_MUTE_EN
    if (mute_toggle) m_muted = !m_muted;
`endif
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later,
  // then all inputs return to idle.
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    chk("level",   int'(level),   m_level);
    chk("target",  int'(target),  m_target);
    chk("muted",   int'(muted),   int'(m_muted));
    chk("ramping", int'(ramping), int'(m_ramp));
    reset = 0; vol_up = 0; vol_down = 0; mute_toggle = 0; sample_tick = 0;
  endtask

  task automatic do_reset();
    reset = 1; cycle();
    reset = 1; cycle();
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      sample_tick = 1; cycle();
      cycle();
    end
  endtask

  initial begin
    reset = 1; vol_up = 0; vol_down = 0; mute_toggle = 0; sample_tick = 0;
    m_target = 3; m_level = 3; m_muted = 0; m_ramp = 0; m_ticks = 0;

    // Reset values; ticks while idle do nothing
    do_reset();
    chk("rst_level", int'(level), 3);
    chk("rst_target", int'(target), 3);
    chk("rst_muted", int'(muted), 0);
    chk("rst_ramping", int'(ramping), 0);
    chk("rst_cnt", int'(dut.u_div.cnt), 0);
    tick_n(6);
    chk("idle_ticks_level", int'(level), 3);

    // Two-step descent
    vol_down = 1; cycle();
    vol_down = 1; cycle();
    chk("desc_target", int'(target), 1);
    cycle();
    tick_n(3);
    chk("desc_hold", int'(level), 3);
    tick_n(1);
    chk("desc_step1", int'(level), 2);
    chk("desc_ramping", int'(ramping), 1);
    tick_n(3);
    sample_tick = 1; cycle();
    chk("desc_step2", int'(level), 1);
    chk("desc_done", int'(ramping), 0);

    // Saturation and conflicting keys
    do_reset();
    vol_up = 1; cycle(); cycle();
    chk("sat_target", int'(target), 3);
    chk("sat_ramping", int'(ramping), 0);
    vol_down = 1; cycle();
    vol_up = 1; vol_down = 1; cycle();
    chk("conflict_target", int'(target), 2);

`ifdef VOLUME_MUTE_EN
    // Mute round trip
    do_reset();
    mute_toggle = 1; cycle();
    chk("mute_on", int'(muted), 1);
    chk("mute_target", int'(target), 3);
    cycle();
    tick_n(11);
    chk("mute_l1", int'(level), 1);
    tick_n(1);
    chk("mute_l0", int'(level), 0);
    vol_down = 1; cycle();
    chk("mute_dn_target", int'(target), 2);
    tick_n(5);
    chk("mute_dn_level", int'(level), 0);
    mute_toggle = 1; cycle(); cycle();
    tick_n(8);
    chk("unmute_level", int'(level), 2);
`else
    do_reset();
    mute_toggle = 1; cycle(); cycle();
    tick_n(5);
    chk("nomute_muted", int'(muted), 0);
    chk("nomute_level", int'(level), 3);
`endif

    // Reversal meeting the current level
    do_reset();
    repeat (3) begin vol_down = 1; cycle(); end
    tick_n(4);
    chk("rev_l2", int'(level), 2);
    vol_up = 1; cycle();
    vol_up = 1; cycle();
    cycle();
    chk("rev_idle", int'(ramping), 0);
    tick_n(8);
    chk("rev_hold", int'(level), 2);

    // Reversal back up to 3
    do_reset();
    repeat (2) begin vol_down = 1; cycle(); end
    tick_n(4);
    chk("up_l2", int'(level), 2);
    vol_up = 1; cycle();
    vol_up = 1; cycle();
    cycle();
    tick_n(4);
    chk("up_l3", int'(level), 3);

    // Reset mid-ramp
    vol_down = 1; cycle();
    cycle();
    tick_n(2);
    reset = 1; vol_up = 1; sample_tick = 1; cycle();
    chk("midrst_level", int'(level), 3);
    chk("midrst_ramping", int'(ramping), 0);
    chk("midrst_cnt", int'(dut.u_div.cnt), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      vol_up      = ($urandom_range(15) == 0);
      vol_down    = ($urandom_range(15) == 0);
      mute_toggle = ($urandom_range(29) == 0);
      sample_tick = ($urandom_range(1) == 0);
      reset       = ($urandom_range(499) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/volume_level_sequencer.md
# volume_level_sequencer

Controls the 2-bit `level` input of the stereo volume datapath in response to user key pulses. It keeps a target level (with an optional mute) and moves the applied level toward that target one step at a time, only on audio sample boundaries and at a fixed pace, so volume changes never jump by more than one step. It sits between the debounced key logic and the volume datapath, in the audio clock domain.

## Interface
- `RAMP_TICKS`, default 480: sample ticks between successive level steps (10 ms at 48 kHz); legal range ≥1.
- `INIT_LEVEL`, default 2'b11: level and target value after reset.

- `clock`  in  1  system/audio clock.
- `reset`  in  1  synchronous, active-high reset.
- `vol_up`  in  1  single-cycle pulse; increments target.
- `vol_down`  in  1  single-cycle pulse; decrements target.
- `mute_toggle`  in  1  single-cycle pulse; toggles mute.
- `sample_tick`  in  1  one-cycle strobe per audio sample frame.
- `level`  out  2  applied level driven to the volume datapath.
- `target`  out  2  user-selected level (held through mute).
- `muted`  out  1  mute state.
- `ramping`  out  1  high while `level` ≠ goal.

## Operation
- **Target register:** 0..3, saturating.
  - `vol_up` at 3 and `vol_down` at 0 are ignored.
  - `vol_up` and `vol_down` asserted in the same cycle are ignored.
  - Up/down keys adjust `target` even while muted.
- **Goal:** combinational. `goal = muted ? 0 : target`.
- **FSM states:** IDLE and RAMP. 16-bit tick counter `cnt`.
  - IDLE: if `goal ≠ level`, go to RAMP and set `cnt = RAMP_TICKS-1`.
  - RAMP with `goal == level`: go to IDLE and clear `cnt`. This covers a goal reversal that meets the current level.
  - RAMP, on `sample_tick` with `cnt ≠ 0`: `cnt--`.
  - RAMP, on `sample_tick` with `cnt == 0`: step `level` by one toward `goal`.
    - If the new level equals `goal`, go to IDLE.
    - Otherwise reload `cnt = RAMP_TICKS-1` and stay in RAMP.
  - The step direction is re-evaluated at every step from the current goal. If the goal changes mid-ramp, the count is not restarted.
- `ramping` = (state == RAMP). It is registered.
- A key pulse and a level step in the same cycle are both honoured. The step uses the goal from before the pulse.

## Timing
- **Reset values:** `level = INIT_LEVEL`, `target = INIT_LEVEL`, `muted = 0`, `ramping = 0`, `cnt = 0`, state = IDLE.
- All outputs are registered.
- Key pulse in cycle N → `target`/`muted` updated at N+1 → `ramping` = 1 at N+2.
- The first step comes on the RAMP_TICKS-th `sample_tick` seen while in RAMP. `level` updates the cycle after that tick.
- Ticks that arrive while in IDLE are not counted.
- Each further step takes RAMP_TICKS ticks. A change of k levels takes k·RAMP_TICKS ticks.
- With `RAMP_TICKS = 1`, the level steps on every tick.
- **Reset mid-ramp:** reset has priority over every input. All state returns to the reset values on the next edge.

## Configuration
- **`VOLUME_MUTE_EN` defined:** mute behaves as described above.
- **`VOLUME_MUTE_EN` undefined:**
  - The `mute_toggle` port remains but is ignored.
  - `muted` is tied to 0 and `goal = target`.
  - No mute register is synthesised.

## Structure
- Package `volume_ctrl_pkg` holds:
  - constants `LEVEL_OFF = 2'b00` and `LEVEL_FULL = 2'b11`;
  - the level typedef `level_t` (2 bits);
  - the FSM state enum `vseq_state_t` {IDLE, RAMP}.
- One sub-module is natural: `tick_divider`, a loadable down-counter gated by `sample_tick` that flags on reaching zero.
- The target/mute register and the FSM stay in the top module.

## Test plan
All scenarios use `RAMP_TICKS = 4` and assume `VOLUME_MUTE_EN` is defined.
- **Reset.** Assert reset → `level = 3`, `target = 3`, `muted = 0`, `ramping = 0`. Ticks while IDLE leave `level` unchanged.
- **Two-step descent.** Two `vol_down` pulses → `target = 1`. `level` goes 3→2 after the 4th tick and 2→1 after the 8th. `ramping` deasserts the cycle after the 8th tick.
- **Saturation and conflict.**
  - `vol_up` at `target = 3` → no change, `ramping` stays 0.
  - `vol_up` and `vol_down` in the same cycle at `target = 2` → `target` stays 2.
- **Mute round trip.**
  - At level 3, `mute_toggle` → `muted = 1`, `target = 3`, `level` reaches 0 after 12 ticks.
  - `vol_down` while muted → `target = 2`, `level` stays 0.
  - `mute_toggle` again → `level` reaches 2 after 8 ticks.
- **Reversal mid-ramp.**
  - Ramp 3→0 is under way; after `level = 2`, send `vol_up` twice so the goal becomes 2 → IDLE on the next cycle, `level` holds at 2.
  - Separately: with the goal at 3 after `level = 2`, the next step (4 ticks after the previous step) goes to 3.
- **Reset mid-ramp and the undefined-macro build.**
  - Reset asserted during a ramp → next cycle `level = 3`, `ramping = 0`, `cnt = 0`.
  - Build without `VOLUME_MUTE_EN`: `mute_toggle` pulses leave `muted = 0` and `level` unchanged.
